lif_step_scheduler: RTL and testbench

//  Time-multiplexed sequencer for the LIF neuron datapath: one update engine is shared by
//  NUM_NEURONS virtual neurons whose membrane and refractory state live in internal registers.

---
 rtl/lif_step_scheduler.sv | 104 ++++++++++
 tb/tb_lif_step_scheduler.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler: time-multiplexed leaky integrate-and-fire update sequencer
// Ports: clk/rst (sync, active-high); step_start pulse begins a timestep over all neurons;
// cur_in is the current for cur_idx, sampled in FETCH; threshold/leak_shift held while busy;
// spike_valid/spike_idx report each fire; spike_vec holds the last step's fires; done ends a step.
module lif_step_scheduler #(
   parameter int NUM_NEURONS = 4,
   parameter int W = 8,
   parameter int REFRACT = 2,
   localparam int IW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
   localparam int RW = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   step_start,
   input  logic [W-1:0]           cur_in,
   input  logic [W-1:0]           threshold,
   input  logic [2:0]             leak_shift,
   output logic [IW-1:0]          cur_idx,
   output logic                   busy,
   output logic                   spike_valid,
   output logic [IW-1:0]          spike_idx,
   output logic [NUM_NEURONS-1:0] spike_vec,
   output logic                   done
);
   typedef enum logic [1:0] {IDLE, FETCH, UPDATE, DONE} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0] cur_q;
   logic [W-1:0] v_q [NUM_NEURONS];
   logic [RW-1:0] refr_q [NUM_NEURONS];
   logic [NUM_NEURONS-1:0] fires_q, spike_vec_q;
   logic spike_valid_q;
   logic [IW-1:0] spike_idx_q;
   logic last;
   logic [W-1:0] v_cur, leak, sat;
   logic [RW-1:0] r_cur;
   logic [W:0] sum;
   logic refr_busy, fire;
   always_comb begin
      last = idx_q == IW'(NUM_NEURONS - 1);
      state_d = state_q;
      idx_d = idx_q;
      unique case (state_q)
         IDLE:    state_d = step_start ? FETCH : IDLE;
         FETCH:   state_d = UPDATE;
         UPDATE: begin
            state_d = last ? DONE : FETCH;
            idx_d = last ? '0 : idx_q + IW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   // leak_shift==0 means the whole membrane leaks away before integrating
   always_comb begin
      v_cur = v_q[idx_q];
      r_cur = refr_q[idx_q];
      leak = (leak_shift == 3'd0) ? v_cur : v_cur >> leak_shift;
      sum = {1'b0, v_cur - leak} + (W + 1)'(cur_q);
      sat = sum[W] ? '1 : sum[W-1:0];
      refr_busy = r_cur != '0;
      fire = (state_q == UPDATE) && !refr_busy && (sat >= threshold);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q <= '0;
         cur_q <= '0;
         fires_q <= '0;
         spike_vec_q <= '0;
         spike_valid_q <= 1'b0;
         spike_idx_q <= '0;
         for (int i = 0; i < NUM_NEURONS; i++) begin
            v_q[i] <= '0;
            refr_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q <= idx_d;
         spike_valid_q <= fire;
         if (fire) spike_idx_q <= idx_q;
         if (state_q == FETCH) cur_q <= cur_in;
         if (state_q == IDLE && step_start) fires_q <= '0;
         if (state_q == UPDATE) begin
            if (refr_busy) begin
               refr_q[idx_q] <= r_cur - RW'(1);
               v_q[idx_q] <= '0;
            end else if (fire) begin
               v_q[idx_q] <= '0;
               refr_q[idx_q] <= RW'(REFRACT);
               fires_q[idx_q] <= 1'b1;
            end else begin
               v_q[idx_q] <= sat;
            end
         end
         if (state_q == DONE) spike_vec_q <= fires_q;
      end
   end
   assign cur_idx = idx_q;
   assign busy = state_q != IDLE;
   assign done = state_q == DONE;
   assign spike_valid = spike_valid_q;
   assign spike_idx = spike_idx_q;
   assign spike_vec = spike_vec_q;
endmodule

// File: tb/tb_lif_step_scheduler.sv
// tb_lif_step_scheduler: scoreboard bench for the LIF step scheduler
module tb_lif_step_scheduler;
   localparam int N = 4;
   localparam int REFR = 2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic step_start = 1'b0;
   logic [7:0] cur_in;
   logic [7:0] threshold = 8'd0;
   logic [2:0] leak_shift = 3'd0;
   logic [1:0] cur_idx;
   logic busy, spike_valid, done;
   logic [1:0] spike_idx;
   logic [3:0] spike_vec;
   typedef struct {int idx; int k;} exp_t;
   exp_t exp_q[$];
   int cur_tab [N];
   int mv [N];
   int mr [N];
   int exp_vec;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   assign cur_in = 8'(cur_tab[cur_idx]);
   lif_step_scheduler #(.NUM_NEURONS(N), .W(8), .REFRACT(REFR)) dut (
      .clk(clk), .rst(rst), .step_start(step_start), .cur_in(cur_in),
      .threshold(threshold), .leak_shift(leak_shift), .cur_idx(cur_idx),
      .busy(busy), .spike_valid(spike_valid), .spike_idx(spike_idx),
      .spike_vec(spike_vec), .done(done)
   );
   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = 0;
         mr[i] = 0;
      end
      exp_q.delete();
   endtask
   task automatic model_step(input int thr, input int ls);
      int l, s;
      exp_vec = 0;
      for (int i = 0; i < N; i++) begin
         if (mr[i] != 0) begin
            mr[i]--;
            mv[i] = 0;
         end else begin
            l = (ls == 0) ? mv[i] : (mv[i] >> ls);
            s = mv[i] - l + cur_tab[i];
            if (s > 255) s = 255;
            if (s >= thr) begin
               mv[i] = 0;
               mr[i] = REFR;
               exp_vec |= (1 << i);
               exp_q.push_back('{idx: i, k: 3 + 2 * i});
            end else begin
               mv[i] = s;
            end
         end
      end
   endtask
   task automatic check_spike(input int k);
      exp_t e;
      if (spike_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_spike: got idx %0d at cycle %0d, required none", spike_idx, k);
         end else begin
            e = exp_q.pop_front();
            if (int'(spike_idx) !== e.idx || k != e.k) begin
               errors++;
               $display("FAIL spike: got idx %0d cycle %0d, required idx %0d cycle %0d", spike_idx, k, e.idx, e.k);
            end
         end
      end
   endtask
   task automatic do_reset();
      rst = 1'b1;
      step_start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask
   task automatic do_step(input int thr, input int ls, input bit noise);
      threshold = 8'(thr);
      leak_shift = 3'(ls);
      model_step(thr, ls);
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      for (int k = 1; k <= 2 * N + 2; k++) begin
         @(negedge clk);
         checks++;
         if (busy !== (k <= 2 * N + 1)) begin
            errors++;
            $display("FAIL busy: got %b at cycle %0d, required %b", busy, k, k <= 2 * N + 1);
         end
         checks++;
         if (done !== (k == 2 * N + 1)) begin
            errors++;
            $display("FAIL done: got %b at cycle %0d, required %b", done, k, k == 2 * N + 1);
         end
         if (k % 2 == 1 && k < 2 * N) begin
            checks++;
            if (int'(cur_idx) !== (k - 1) / 2) begin
               errors++;
               $display("FAIL cur_idx: got %0d at cycle %0d, required %0d", cur_idx, k, (k - 1) / 2);
            end
         end
         check_spike(k);
         if (k == 2 * N + 2) begin
            checks++;
            if (int'(spike_vec) !== exp_vec) begin
               errors++;
               $display("FAIL spike_vec: got %b, required %b", spike_vec, 4'(exp_vec));
            end
            checks++;
            if (exp_q.size() != 0) begin
               errors++;
               $display("FAIL missing_spike: got none, required idx %0d", exp_q[0].idx);
               exp_q.delete();
            end
         end
         step_start = noise && (k == 3 || k == 2 * N + 1);
      end
      step_start = 1'b0;
   endtask
   task automatic set_cur(input int c0, input int c1, input int c2, input int c3);
      cur_tab[0] = c0;
      cur_tab[1] = c1;
      cur_tab[2] = c2;
      cur_tab[3] = c3;
   endtask
   task automatic test_reset();
      set_cur(0, 0, 0, 0);
      do_reset();
      checks++;
      if ({busy, done, spike_valid, spike_idx, spike_vec, cur_idx} !== 11'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 0", {busy, done, spike_valid, spike_idx, spike_vec, cur_idx});
      end
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         checks++;
         if ({busy, done, spike_valid, spike_vec} !== 7'd0) begin
            errors++;
            $display("FAIL idle: got %b at cycle %0d, required 0", {busy, done, spike_valid, spike_vec}, k);
         end
      end
   endtask
   task automatic test_no_spike();
      do_reset();
      set_cur(10, 10, 10, 10);
      do_step(200, 0, 1'b0);
      set_cur(0, 0, 0, 0);
      do_step(10, 7, 1'b0);
   endtask
   task automatic test_fire_refractory();
      do_reset();
      set_cur(100, 100, 100, 100);
      repeat (6) do_step(150, 7, 1'b0);
   endtask
   task automatic test_saturation();
      do_reset();
      set_cur(255, 200, 200, 255);
      repeat (7) do_step(255, 7, 1'b0);
   endtask
   task automatic test_threshold_zero();
      do_reset();
      set_cur(0, 7, 0, 3);
      repeat (4) do_step(0, 2, 1'b0);
   endtask
   task automatic test_mixed();
      do_reset();
      set_cur(50, 120, 200, 30);
      repeat (5) do_step(150, 1, 1'b0);
   endtask
   task automatic test_back_to_back();
      do_reset();
      set_cur(60, 90, 140, 20);
      repeat (4) do_step(130, 3, 1'b1);
   endtask
   task automatic test_reset_mid();
      do_reset();
      set_cur(0, 0, 50, 50);
      do_step(40, 7, 1'b0);
      threshold = 8'd0;
      exp_q.push_back('{idx: 0, k: 3});
      exp_q.push_back('{idx: 1, k: 5});
      step_start = 1'b1;
      @(posedge clk);
      #1 step_start = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0) begin
            errors++;
            $display("FAIL mid_done: got %b at cycle %0d, required 0", done, k);
         end
         check_spike(k);
         if (k >= 7) begin
            checks++;
            if ({busy, spike_vec, cur_idx} !== 7'd0) begin
               errors++;
               $display("FAIL mid_cleared: got %b at cycle %0d, required 0", {busy, spike_vec, cur_idx}, k);
            end
         end
         rst = (k == 6);
      end
      rst = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL mid_missing_spike: got none, required idx %0d", exp_q[0].idx);
      end
      model_reset();
      set_cur(0, 0, 0, 0);
      do_step(0, 7, 1'b0);
   endtask
   initial begin
      test_reset();
      test_no_spike();
      test_fire_refractory();
      test_saturation();
      test_threshold_zero();
      test_mixed();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
